// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared constants, FSM encoding and divisor helper for uart_rx_gen
// Revision: 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Nearest-integer clock divisor that yields one oversample tick.
    function automatic int div_round(input int clk_hz, input int baud, input int oversample);
        int den;
        den = baud * oversample;
        return (clk_hz + den / 2) / den;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_gen_if.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_gen_if
// Brief   : Received-word handshake bundle between the UART receiver and its consumer
// Revision: 1.0  initial release
// ============================================================================
interface uart_rx_gen_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun_err;

    modport master (
        output rx_data, rx_valid, parity_err, frame_err, overrun_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, parity_err, frame_err, overrun_err,
        output rx_ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module  : uart_baud_tick
// Brief   : Free-running oversample tick divider, re-phased by restart
// Revision: 1.0  initial release
// ============================================================================
module uart_baud_tick #(
    parameter int DIV = 651
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic restart,
    output logic      tick
);
    localparam int              c_CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(DIV - 1);

    logic [c_CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == c_LAST) && !restart;
endmodule
`default_nettype wire

// File: rtl/uart_rx_gen.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_gen
// Brief   : Oversampling UART receiver with majority vote and valid/ready output
// Revision: 1.0  initial release
// ============================================================================
module uart_rx_gen
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  wire logic     clk,
    input  wire logic     rst,
    input  wire logic     rxd_in,
    uart_rx_gen_if.master rx
);
    localparam int              c_DIV       = div_round(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int              c_TW        = $clog2(OVERSAMPLE);
    localparam logic [c_TW-1:0] c_T_S0      = c_TW'(OVERSAMPLE / 2 - 1);
    localparam logic [c_TW-1:0] c_T_S1      = c_TW'(OVERSAMPLE / 2);
    localparam logic [c_TW-1:0] c_T_VOTE    = c_TW'(OVERSAMPLE / 2 + 1);
    localparam logic [c_TW-1:0] c_T_END     = c_TW'(OVERSAMPLE - 1);
    localparam logic [3:0]      c_LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]      c_LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic            c_ODD       = (PARITY == PAR_ODD);

    generate
        if (c_DIV < 1 || !(OVERSAMPLE == 8 || OVERSAMPLE == 16) ||
            DATA_BITS < 5 || DATA_BITS > 9 || PARITY < PAR_NONE || PARITY > PAR_EVEN ||
            !(STOP_BITS == 1 || STOP_BITS == 2)) begin : g_bad_param
            $error("uart_rx_gen: illegal parameter combination");
        end
    endgenerate

    logic [1:0]           r_sync;
    logic                 r_rxd_prev;
    logic                 w_rxd;
    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_tick;
    logic                 w_start_det;
    logic                 w_complete;
    logic [c_TW-1:0]      r_tick_cnt;
    logic [3:0]           r_bit_cnt;
    logic                 r_s0;
    logic                 r_s1;
    logic                 w_vote;
    logic                 w_at_vote;
    logic                 w_at_end;
    logic                 w_par_exp;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_err;
    logic                 r_frm_err;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_overrun;

    assign w_rxd     = r_sync[1];
    assign w_at_vote = w_tick && (r_tick_cnt == c_T_VOTE);
    assign w_at_end  = w_tick && (r_tick_cnt == c_T_END);
    assign w_vote    = (r_s0 & r_s1) | (r_s0 & w_rxd) | (r_s1 & w_rxd);
    assign w_par_exp = (^r_shift) ^ c_ODD;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync     <= 2'b11;
            r_rxd_prev <= 1'b1;
        end else begin
            r_sync     <= {r_sync[0], rxd_in};
            r_rxd_prev <= r_sync[1];
        end
    end

    uart_baud_tick #(.DIV(c_DIV)) u_baud (
        .clk     (clk),
        .rst     (rst),
        .restart (w_start_det),
        .tick    (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The frame completes on the last stop-bit vote, half a bit early, so a
    // back-to-back start edge is never missed.
    always_comb begin
        w_state_nxt = r_state;
        w_start_det = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_rxd_prev && !w_rxd) begin
                    w_state_nxt = ST_START;
                    w_start_det = 1'b1;
                end
            end
            ST_START: begin
                if (w_at_vote && w_vote) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_at_end) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_at_end && (r_bit_cnt == c_LAST_DATA)) begin
                    w_state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (w_at_end) begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_at_vote && (r_bit_cnt == c_LAST_STOP)) begin
                    w_state_nxt = ST_IDLE;
                    w_complete  = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_s0       <= 1'b1;
            r_s1       <= 1'b1;
            r_shift    <= '0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
        end else if (w_start_det) begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
        end else if (w_tick) begin
            r_tick_cnt <= (r_tick_cnt == c_T_END) ? '0 : r_tick_cnt + 1'b1;
            if (r_tick_cnt == c_T_S0) begin
                r_s0 <= w_rxd;
            end
            if (r_tick_cnt == c_T_S1) begin
                r_s1 <= w_rxd;
            end
            if (r_tick_cnt == c_T_VOTE) begin
                case (r_state)
                    ST_DATA:   r_shift   <= {w_vote, r_shift[DATA_BITS-1:1]};
                    ST_PARITY: r_par_err <= (w_vote != w_par_exp);
                    ST_STOP:   r_frm_err <= r_frm_err | ~w_vote;
                    default:   ;
                endcase
            end
            if (r_tick_cnt == c_T_END) begin
                if (r_state == ST_DATA && r_bit_cnt == c_LAST_DATA) begin
                    r_bit_cnt <= '0;
                end else if (r_state == ST_DATA || r_state == ST_STOP) begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end
        end
    end

    // The final stop vote is folded in directly; it is not yet in r_frm_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_complete) begin
                if (!r_valid || rx.rx_ready) begin
                    r_data  <= r_shift;
                    r_perr  <= r_par_err;
                    r_ferr  <= r_frm_err | ~w_vote;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && rx.rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx.rx_data     = r_data;
    assign rx.rx_valid    = r_valid;
    assign rx.parity_err  = r_perr;
    assign rx.frame_err   = r_ferr;
    assign rx.overrun_err = r_overrun;
endmodule
`default_nettype wire
